// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART baud tick generator.
//   - baud_sel_e : 3-bit rate-select encoding (0:1200 ... 7:115200)
//   - BAUD_RATE  : baud rate in Hz for each baud_sel value
//   - calc_div   : elaboration-time divisor computation
//   - DEFAULT_OVERSAMPLE, RESET_SEL : defaults used by the generator
package uart_pkg;

    typedef enum logic [2:0] {
        BAUD_1200   = 3'd0,
        BAUD_2400   = 3'd1,
        BAUD_4800   = 3'd2,
        BAUD_9600   = 3'd3,
        BAUD_19200  = 3'd4,
        BAUD_38400  = 3'd5,
        BAUD_57600  = 3'd6,
        BAUD_115200 = 3'd7
    } baud_sel_e;

    localparam int unsigned DEFAULT_OVERSAMPLE = 16;
    localparam baud_sel_e   RESET_SEL          = BAUD_9600;

    localparam int unsigned BAUD_RATE [8] = '{
        1200, 2400, 4800, 9600, 19200, 38400, 57600, 115200
    };

    // DIV = round(clk_freq * 2^frac_w / (baud * os)), in 64-bit arithmetic.
    function automatic longint unsigned calc_div(
        input longint unsigned clk_freq,
        input int unsigned     os,
        input int unsigned     frac_w,
        input int unsigned     baud
    );
        longint unsigned num;
        longint unsigned den;
        num = clk_freq << frac_w;
        den = 64'(baud) * 64'(os);
        return (2 * num + den) / (2 * den);
    endfunction

endpackage

// File: rtl/uart_baud_tick_gen_frac_tick_div.sv
// frac_tick_div: fractional phase accumulator producing the oversample tick.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : advance the accumulator by 2^FRAC_W this cycle
//   clear      : force the accumulator to 0; suppresses tick
//   div        : divisor with FRAC_W fractional bits
//   tick       : combinational, high in the cycle the accumulator wraps
module frac_tick_div #(
    parameter int unsigned DIV_W  = 18,
    parameter int unsigned FRAC_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clear,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    localparam logic [DIV_W:0] STEP = {{DIV_W{1'b0}}, 1'b1} << FRAC_W;

    logic [DIV_W-1:0] acc;
    logic [DIV_W:0]   nxt;
    logic [DIV_W:0]   wrapped;
    logic             hit;

    // One extra bit so the sum cannot overflow before the compare.
    assign nxt     = {1'b0, acc} + STEP;
    assign wrapped = nxt - {1'b0, div};
    assign hit     = nxt >= {1'b0, div};
    assign tick    = en & ~clear & hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (en) begin
            acc <= hit ? wrapped[DIV_W-1:0] : nxt[DIV_W-1:0];
        end
    end

endmodule

// File: rtl/uart_baud_tick_gen.sv
// uart_baud_tick_gen: baud-rate strobe generator shared by UART TX and RX.
//   clk, rst_n  : clock, asynchronous active-low reset
//   en          : enable; low keeps the generator idle and cleared
//   baud_sel    : requested rate (see uart_pkg::baud_sel_e)
//   resync      : one-cycle pulse restarting the bit phase at 0
//   os_tick     : one-cycle strobe at OVERSAMPLE x baud
//   bit_tick    : one-cycle strobe at each bit boundary
//   mid_tick    : one-cycle strobe at bit centre
//   os_cnt      : os_ticks since the last bit boundary
//   active_sel  : rate currently in effect
module uart_baud_tick_gen
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned OVERSAMPLE = DEFAULT_OVERSAMPLE,
    parameter int unsigned FRAC_W     = 4,
    parameter int unsigned DIV_W      = 18
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic [2:0]                    baud_sel,
    input  logic                          resync,
    output logic                          os_tick,
    output logic                          bit_tick,
    output logic                          mid_tick,
    output logic [$clog2(OVERSAMPLE)-1:0] os_cnt,
    output logic [2:0]                    active_sel
);

    localparam int unsigned       CNT_W    = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0]  CNT_PRE_MID = CNT_W'(OVERSAMPLE / 2 - 1);

    if (OVERSAMPLE < 4 || (OVERSAMPLE & (OVERSAMPLE - 1)) != 0) begin : g_bad_os
        $error("OVERSAMPLE must be a power of 2 and at least 4");
    end

    logic [DIV_W-1:0] div_tab [8];

    for (genvar g = 0; g < 8; g++) begin : g_div
        localparam longint unsigned DIV = calc_div(CLK_FREQ, OVERSAMPLE, FRAC_W, BAUD_RATE[g]);
        if (DIV >= (64'd1 << DIV_W) || DIV < (64'd2 << FRAC_W)) begin : g_bad_div
            $error("baud divisor out of range for DIV_W/FRAC_W");
        end
        assign div_tab[g] = DIV_W'(DIV);
    end

    logic             en_q;
    logic             restart;
    logic             tick;
    logic             bit_end;
    logic             bit_mid;
    logic [DIV_W-1:0] div;

    // The first enabled cycle is treated as a restart so that start-up
    // latency matches the resync case exactly.
    assign restart = ~en | resync | ~en_q;
    assign div     = div_tab[active_sel];
    assign bit_end = tick && (os_cnt == CNT_LAST);
    assign bit_mid = tick && (os_cnt == CNT_PRE_MID);

    frac_tick_div #(
        .DIV_W  (DIV_W),
        .FRAC_W (FRAC_W)
    ) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .clear (restart),
        .div   (div),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q       <= 1'b0;
            os_tick    <= 1'b0;
            bit_tick   <= 1'b0;
            mid_tick   <= 1'b0;
            os_cnt     <= '0;
            active_sel <= RESET_SEL;
        end else begin
            en_q     <= en;
            os_tick  <= tick;
            bit_tick <= bit_end;
            mid_tick <= bit_mid;
            if (restart) begin
                os_cnt     <= '0;
                active_sel <= baud_sel;
            end else if (tick) begin
                os_cnt <= os_cnt + 1'b1;
                // Rate switches only at a bit boundary so partial bits finish at the old rate.
                if (bit_end) begin
                    active_sel <= baud_sel;
                end
            end
        end
    end

endmodule
